// File: rtl/io_led_uart.sv
// io_led_uart
// Memory-mapped LED and UART-TX responder on the CPU data bus.
// Selected when mem_addr[22]=1. The register index is mem_addr[3:2]:
//   0 LED     : W lane0 -> led_reg = wdata[5:0]; R -> {26'b0, led_reg}
//   1 TXDATA  : W lane0 -> push wdata[7:0] into the TX FIFO; R -> 0
//   2 STATUS  : R -> {28'b0, ovf, fifo_empty, fifo_full, tx_busy}
//               W with wdata[3]=1 clears ovf
//   3 reserved: R -> 0, writes ignored
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   mem_addr   byte address from the core
//   mem_wdata  store data
//   mem_wmask  byte-lane write enables (nonzero = write)
//   mem_rstrb  one-cycle load strobe
//   mem_rdata  registered read data, held between strobes
//   leds       active-low LED pins
//   uart_tx    8N1 serial output, idles high
module io_led_uart #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic [5:0]  leds,
    output logic        uart_tx
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW-1:0] PTR_LAST  = AW'(FIFO_DEPTH - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_baud, w_baud_nxt;
    logic [2:0]     r_bit, w_bit_nxt;
    logic [7:0]     r_shift, w_shift_nxt;
    logic           r_tx, w_tx_nxt;
    logic [5:0]     r_leds;          // holds the pin value, i.e. ~led_reg
    logic           r_ovf;
    logic [31:0]    r_rdata;
    logic [7:0]     r_fifo [FIFO_DEPTH];
    logic [AW-1:0]  r_wptr, r_rptr;
    logic [AW:0]    r_count;

    logic           w_sel, w_wr, w_push_req, w_push, w_pop, w_ovf_set, w_ovf_clr;
    logic           w_full, w_empty, w_busy;
    logic [1:0]     w_idx;
    logic [31:0]    w_status, w_rd_val;
    logic           w_unused_bits;

    assign w_sel      = mem_addr[22];
    assign w_idx      = mem_addr[3:2];
    assign w_wr       = w_sel && (mem_wmask != 4'd0);
    assign w_push_req = w_wr && (w_idx == 2'd1) && mem_wmask[0];
    assign w_full     = (r_count == CNT_FULL);
    assign w_empty    = (r_count == {(AW + 1){1'b0}});
    // A full FIFO still accepts a byte when the FSM pops in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && w_full && !w_pop;
    assign w_ovf_clr  = w_wr && (w_idx == 2'd2) && mem_wdata[3];
    assign w_busy     = (r_state != S_IDLE) || !w_empty;
    assign w_status   = {28'd0, r_ovf, w_empty, w_full, w_busy};

    assign mem_rdata  = r_rdata;
    assign leds       = r_leds;
    assign uart_tx    = r_tx;

    assign w_unused_bits = &{mem_addr[31:23], mem_addr[21:4], mem_addr[1:0], mem_wdata[31:8]};

    // Read-data mux for the addressed register.
    always_comb begin
        w_rd_val = 32'd0;
        if (w_sel) begin
            case (w_idx)
                2'd0:    w_rd_val = {26'd0, ~r_leds};
                2'd2:    w_rd_val = w_status;
                default: w_rd_val = 32'd0;
            endcase
        end else begin
            w_rd_val = 32'd0;
        end
    end

    // Bus-side registers: LED, sticky overflow, read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_leds  <= 6'b111111;
            r_ovf   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            if (w_wr && (w_idx == 2'd0) && mem_wmask[0]) begin
                r_leds <= ~mem_wdata[5:0];
            end
            // Set has priority over a same-cycle clear.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (mem_rstrb) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    // TX FIFO storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= 8'd0;
            end
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {(AW + 1){1'b0}};
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= mem_wdata[7:0];
                r_wptr <= (r_wptr == PTR_LAST) ? {AW{1'b0}} : r_wptr + {{(AW - 1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_LAST) ? {AW{1'b0}} : r_rptr + {{(AW - 1){1'b0}}, 1'b1};
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    // TX FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_baud  <= {CW{1'b0}};
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // TX FSM next state, pop and line level. The line follows the current
    // state one cycle late, which gives the write-to-start-bit latency of 2.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        w_tx_nxt    = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_fifo[r_rptr];
                    w_baud_nxt  = {CW{1'b0}};
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                w_tx_nxt = 1'b0;
                if (r_baud == BAUD_LAST) begin
                    w_baud_nxt  = {CW{1'b0}};
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + {{(CW - 1){1'b0}}, 1'b1};
                end
            end
            S_DATA: begin
                w_tx_nxt = r_shift[0];
                if (r_baud == BAUD_LAST) begin
                    w_baud_nxt  = {CW{1'b0}};
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud + {{(CW - 1){1'b0}}, 1'b1};
                end
            end
            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (r_baud == BAUD_LAST) begin
                    w_baud_nxt = {CW{1'b0}};
                    // Chain straight into the next frame when data is waiting.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_fifo[r_rptr];
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + {{(CW - 1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_io_led_uart.sv
// Self-checking bench for io_led_uart: LED/register vector table, a UART line
// decoder feeding a received-byte queue, hand sequences for timing corners and
// randomized traffic checked against a simple register/byte-queue model.
module tb_io_led_uart;

    localparam int C = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [3:0]  mem_wmask = 4'd0;
    logic        mem_rstrb = 1'b0;
    logic [31:0] mem_rdata;
    logic [5:0]  leds;
    logic        uart_tx;

    io_led_uart #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .leds      (leds),
        .uart_tx   (uart_tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] rx_q[$];
    int         st_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Line decoder: samples each bit near its centre on the falling clock edge.
    initial begin : monitor
        logic       prev;
        logic [7:0] b;
        int         sc;
        prev = 1'b1;
        b = 8'd0;
        forever begin
            @(negedge clk);
            if (rst && prev && !uart_tx) begin
                sc = cyc;
                repeat (C / 2 - 1) @(negedge clk);
                chk("start_bit", {31'd0, uart_tx}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (C) @(negedge clk);
                chk("stop_bit", {31'd0, uart_tx}, 32'd1);
                rx_q.push_back(b);
                st_q.push_back(sc);
                prev = 1'b1;
            end else begin
                prev = uart_tx;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Both tasks start and end just after a falling edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        mem_addr  = a;
        mem_wdata = d;
        mem_wmask = m;
        @(negedge clk);
        mem_wmask = 4'd0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        mem_addr  = a;
        mem_rstrb = 1'b1;
        @(negedge clk);
        mem_rstrb = 1'b0;
        d = mem_rdata;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        is_rd;
        logic [5:0]  exp_leds;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[14];

    initial begin : main
        logic [31:0] d;
        logic [7:0]  exp_b[$];
        logic [5:0]  led_m;
        logic [31:0] last_rd;
        int          wc, n0, len;

        tbl[0]  = '{32'h0040_0000, 32'h2A, 4'hF, 1'b0, 6'b010101, 32'h4};
        tbl[1]  = '{32'h0040_0000, 32'h00, 4'h0, 1'b1, 6'b010101, 32'h2A};
        tbl[2]  = '{32'h0040_0000, 32'h15, 4'h0, 1'b0, 6'b010101, 32'h2A};
        tbl[3]  = '{32'h0000_0000, 32'h3F, 4'hF, 1'b0, 6'b010101, 32'h2A};
        tbl[4]  = '{32'h0000_0000, 32'h00, 4'h0, 1'b1, 6'b010101, 32'h0};
        tbl[5]  = '{32'h0040_0000, 32'h3F, 4'h2, 1'b0, 6'b010101, 32'h0};
        tbl[6]  = '{32'h0040_000C, 32'hFF, 4'hF, 1'b0, 6'b010101, 32'h0};
        tbl[7]  = '{32'h0040_000C, 32'h00, 4'h0, 1'b1, 6'b010101, 32'h0};
        tbl[8]  = '{32'h0040_0000, 32'h07, 4'h1, 1'b0, 6'b111000, 32'h0};
        tbl[9]  = '{32'h0040_0010, 32'h00, 4'h0, 1'b1, 6'b111000, 32'h7};
        tbl[10] = '{32'h0040_0008, 32'h00, 4'h0, 1'b1, 6'b111000, 32'h4};
        tbl[11] = '{32'h0040_0004, 32'h00, 4'h0, 1'b1, 6'b111000, 32'h0};
        tbl[12] = '{32'h00C0_0000, 32'h00, 4'h0, 1'b1, 6'b111000, 32'h7};
        tbl[13] = '{32'h0080_0000, 32'h00, 4'h0, 1'b1, 6'b111000, 32'h0};

        // ---------------- reset ----------------
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_leds", {26'd0, leds}, 32'h3F);
        chk("rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_rdata", mem_rdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rd(32'h0040_0008, d);
        chk("rst_status", d, 32'h4);

        // ---------------- register vector table ----------------
        foreach (tbl[i]) begin
            if (tbl[i].is_rd) rd(tbl[i].addr, d);
            else              wr(tbl[i].addr, tbl[i].wdata, tbl[i].wmask);
            chk($sformatf("tbl%0d_leds", i), {26'd0, leds}, {26'd0, tbl[i].exp_leds});
            chk($sformatf("tbl%0d_rdata", i), mem_rdata, tbl[i].exp_rdata);
        end

        // ---------------- single byte ----------------
        n0 = rx_q.size();
        wr(32'h0040_0004, 32'hA5, 4'hF);
        wc = cyc;
        while (cyc != wc + 160) @(negedge clk);
        rd(32'h0040_0008, d);                  // strobe in the last stop cycle
        chk("single_status_stop", d, 32'h5);
        rd(32'h0040_0008, d);                  // first idle cycle
        chk("single_status_idle", d, 32'h4);
        repeat (10) @(negedge clk);
        chk("single_count", rx_q.size(), n0 + 1);
        if (rx_q.size() > n0) begin
            chk("single_byte", {24'd0, rx_q[n0]}, 32'hA5);
            chk("single_latency", st_q[n0] - wc, 32'd2);
        end

        // ---------------- burst and overflow ----------------
        n0 = rx_q.size();
        wc = 0;
        for (int k = 1; k <= 6; k++) begin
            wr(32'h0040_0004, k, 4'hF);
            if (k == 1) wc = cyc;
        end
        rd(32'h0040_0008, d);
        chk("burst_status_ovf", d, 32'hB);
        repeat (5 * 160 + 40) @(negedge clk);
        chk("burst_count", rx_q.size(), n0 + 5);
        if (rx_q.size() >= n0 + 5) begin
            chk("burst_first_latency", st_q[n0] - wc, 32'd2);
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("burst_byte%0d", k), {24'd0, rx_q[n0 + k]}, k + 1);
                if (k > 0) chk($sformatf("burst_gap%0d", k), st_q[n0 + k] - st_q[n0 + k - 1], 32'd160);
            end
        end
        rd(32'h0040_0008, d);
        chk("burst_status_done", d, 32'hC);
        wr(32'h0040_0008, 32'h8, 4'hF);
        rd(32'h0040_0008, d);
        chk("burst_ovf_cleared", d, 32'h4);

        // ---------------- push/pop collision on a full FIFO ----------------
        n0 = rx_q.size();
        wr(32'h0040_0004, 32'h11, 4'hF);
        wc = cyc;
        wr(32'h0040_0004, 32'h22, 4'hF);
        wr(32'h0040_0004, 32'h33, 4'hF);
        wr(32'h0040_0004, 32'h44, 4'hF);
        wr(32'h0040_0004, 32'h55, 4'hF);
        rd(32'h0040_0008, d);
        chk("coll_status_full", d, 32'h3);
        while (cyc != wc + 160) @(negedge clk);
        wr(32'h0040_0004, 32'h66, 4'hF);       // lands on the STOP->START pop edge
        rd(32'h0040_0008, d);
        chk("coll_status_no_ovf", d, 32'h3);
        repeat (5 * 160 + 40) @(negedge clk);
        chk("coll_count", rx_q.size(), n0 + 6);
        if (rx_q.size() >= n0 + 6) begin
            for (int k = 0; k < 6; k++)
                chk($sformatf("coll_byte%0d", k), {24'd0, rx_q[n0 + k]}, 32'h11 * (k + 1));
        end
        rd(32'h0040_0008, d);
        chk("coll_status_done", d, 32'h4);

        // ---------------- reset mid-frame ----------------
        wr(32'h0040_0004, 32'h55, 4'hF);
        wr(32'h0040_0004, 32'h66, 4'hF);
        repeat (50) @(negedge clk);            // inside the DATA bits of 0x55
        rst = 1'b0;
        #1;
        chk("midrst_tx", {31'd0, uart_tx}, 32'd1);
        chk("midrst_leds", {26'd0, leds}, 32'h3F);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rd(32'h0040_0008, d);
        chk("midrst_status", d, 32'h4);
        repeat (200) @(negedge clk);
        rx_q.delete();
        st_q.delete();
        wr(32'h0040_0004, 32'h3C, 4'hF);
        repeat (180) @(negedge clk);
        chk("midrst_count", rx_q.size(), 32'd1);
        if (rx_q.size() >= 1) chk("midrst_byte", {24'd0, rx_q[0]}, 32'h3C);

        // ---------------- randomized register traffic ----------------
        led_m   = 6'd0;
        last_rd = mem_rdata;
        for (int it = 0; it < 40; it++) begin
            logic [31:0] a, wd, exp;
            logic [3:0]  m;
            logic        sel;
            logic [1:0]  idx;
            sel = 1'($urandom_range(0, 3) != 0);
            idx = 2'($urandom_range(0, 3));
            wd  = $urandom;
            m   = 4'($urandom_range(0, 15));
            a   = {8'd0, 1'b0, sel, 18'($urandom), idx, 2'd0};
            if ($urandom_range(0, 1) == 0) begin
                if (idx == 2'd1) idx = 2'd0;   // keep the transmitter quiet here
                a[3:2] = idx;
                wr(a, wd, m);
                if (sel && m[0] && idx == 2'd0) led_m = wd[5:0];
            end else begin
                rd(a, d);
                exp = 32'd0;
                if (sel && idx == 2'd0) exp = {26'd0, led_m};
                if (sel && idx == 2'd2) exp = 32'h4;
                last_rd = exp;
                chk($sformatf("rand%0d_rdata", it), d, exp);
            end
            chk($sformatf("rand%0d_leds", it), {26'd0, leds}, {26'd0, ~led_m});
            chk($sformatf("rand%0d_hold", it), mem_rdata, last_rd);
        end

        // ---------------- randomized byte bursts ----------------
        for (int r = 0; r < 3; r++) begin
            rx_q.delete();
            exp_b.delete();
            len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++) begin
                logic [7:0] bv;
                bv = 8'($urandom);
                exp_b.push_back(bv);
                wr(32'h0040_0004, {24'd0, bv}, 4'h1);
            end
            repeat (len * 160 + 60) @(negedge clk);
            chk($sformatf("rtx%0d_count", r), rx_q.size(), exp_b.size());
            for (int k = 0; k < len; k++) begin
                if (k < rx_q.size())
                    chk($sformatf("rtx%0d_byte%0d", r, k), {24'd0, rx_q[k]}, {24'd0, exp_b[k]});
            end
        end
        rd(32'h0040_0008, d);
        chk("final_status", d, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_led_uart.md
# io_led_uart

Memory-mapped output peripheral on the CPU data bus: it drives the core's active-low 6-bit LED port and transmits bytes on a serial TX line (8N1). The core issues single-cycle store/load strobes into I/O space. This block is the responder side of that bus: it decodes the access, updates registers and returns read data. It replaces the direct LED wiring, so benches can observe both `leds` and the UART byte stream.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; legal values are 2 or more.
- `FIFO_DEPTH`, default 4: number of TX FIFO entries; must be a power of 2.
- `clk`  in  1: system clock; all state is updated on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `mem_addr`  in  32: byte address from the core.
  - The block is selected when `mem_addr[22]`=1.
  - The register index is `mem_addr[3:2]`.
- `mem_wdata`  in  32: store data.
- `mem_wmask`  in  4: byte-lane write enables. A nonzero value with a selected address means a write.
- `mem_rstrb`  in  1: load strobe, one cycle wide.
- `mem_rdata`  out  32: registered read data.
- `leds`  out  6: LED pins, active low.
- `uart_tx`  out  1: serial output; idles high.

## Operation
- Register map, by index:
  - **0 LED**
    - Write with `mem_wmask[0]`=1: `led_reg` <= `wdata[5:0]`.
    - `leds` = ~`led_reg`.
    - Read returns {26'b0, `led_reg`}.
  - **1 TXDATA**
    - Write with `mem_wmask[0]`=1 pushes `wdata[7:0]` into the FIFO.
    - If the FIFO is full and no pop happens in the same cycle, the byte is dropped and the sticky `ovf` bit is set.
    - Read returns 0.
  - **2 STATUS**
    - Read returns {28'b0, `ovf`, `fifo_empty`, `fifo_full`, `tx_busy`}.
    - Write with `wdata[3]`=1 clears `ovf`.
    - If a clear and a new overflow occur in the same cycle, set wins.
  - **3**: reserved; reads return 0 and writes are ignored.
- Writes with `mem_wmask`=0, or with `mem_addr[22]`=0, have no effect.
- Read path: on a cycle with `mem_rstrb`=1, `mem_rdata` <= the selected register value; it is 0 when the block is unselected. `mem_rdata` holds its value until the next `rstrb`.
- TX FIFO: circular buffer with read and write pointers plus a count.
  - `fifo_full` = (count == `FIFO_DEPTH`).
  - `fifo_empty` = (count == 0).
  - Pointers wrap modulo `FIFO_DEPTH`.
  - A push and a pop in the same cycle are both honoured, with count unchanged, including when the FIFO is full.
- TX FSM states: IDLE, START, DATA, STOP.
  - **IDLE**: `uart_tx`=1. If the FIFO is not empty, pop into the shift register, clear the baud counter and go to START.
  - **START**: `uart_tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - **DATA**: `uart_tx` = `shift[0]` for `CLKS_PER_BIT` cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
  - **STOP**: `uart_tx`=1 for `CLKS_PER_BIT` cycles. At the end, if the FIFO is not empty, pop and go straight to START (back-to-back frames with no extra idle); otherwise go to IDLE.
- `tx_busy` = (state != IDLE) OR !`fifo_empty`.
- `uart_tx` is driven from a register, so there is no combinational glitching.

## Timing
- Reset values: `led_reg`=0 (so `leds`=6'b111111, all off), `uart_tx`=1, `mem_rdata`=0. The FIFO is empty, `ovf`=0 and the FSM is in IDLE.
- Reset asserted mid-frame: `uart_tx` returns to 1 immediately (asynchronously), and FIFO contents are discarded.
- LED write: `leds` changes on the edge after the write cycle, i.e. 1-cycle latency.
- Read: `mem_rdata` is valid on the edge after the `mem_rstrb` cycle. A STATUS read reflects state sampled in the strobe cycle.
- TXDATA write at edge N with the FSM idle and the FIFO empty:
  - The byte is in the FIFO after edge N.
  - It is popped at N+1.
  - `uart_tx` falls at N+2.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles; back-to-back frames are periodic with no gaps.
- `fifo_full`, `fifo_empty` and `ovf` update on the same edge as the push or pop that changes them.

## Test plan
- **Reset:** hold `rst`=0 for 5 cycles, then release.
  - `leds`=6'b111111, `uart_tx`=1, `mem_rdata`=0.
  - A STATUS read returns 0x4 (empty only).
- **LED write/readback:** write 0x2A to addr 0x400000.
  - `leds`=6'b010101 one cycle later.
  - A read of 0x400000 returns 0x2A.
  - A write with `mem_wmask`=0 leaves `leds` unchanged.
- **Single byte:** write 0xA5 to addr 0x400004.
  - `uart_tx` falls 2 cycles later.
  - Sampling at bit centres (`CLKS_PER_BIT`=16) yields start 0, data bits 1,0,1,0,0,1,0,1, then stop 1. Total 160 cycles.
  - Afterwards STATUS returns 0x4.
- **Burst and overflow:** write 0x01..0x06 on consecutive cycles.
  - The first byte is popped immediately and 4 are buffered.
  - The 6th write is dropped; STATUS returns 0xB (busy, full, ovf).
  - The line carries 01,02,03,04,05 back-to-back with no idle bits between frames.
  - Writing 0x8 to STATUS clears `ovf`.
- **Push/pop collision:** with the FIFO full, write TXDATA in the same cycle as a STOP→START pop.
  - The byte is accepted and `ovf` stays 0.
  - The byte is sent last.
- **Reset mid-frame:** assert `rst` during the DATA state.
  - `uart_tx`=1 immediately and the FIFO is empty.
  - After release, a new write of 0x3C transmits correctly.
